// File: rtl/bias_grad_update.sv
// bias_grad_update: per-column bias gradient accumulator and SGD step.
// Sums a batch of Q8.8 gradient samples, then produces
//   bias_new = sat16(bias - sat16((lr * sat16(sum)) >>> FRAC_W))
// as a one-cycle result pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cfg_valid_in; grad_valid_in ignored
// ST_ACCUM  | summing grad samples until batch_size have been seen
// ST_UPDATE | one cycle: saturate sum, apply SGD step, register result
module bias_grad_update #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid_in,
  input  logic [CNT_W-1:0]  batch_size_in,
  input  logic [DATA_W-1:0] lr_in,
  input  logic [DATA_W-1:0] bias_in,
  input  logic              grad_valid_in,
  input  logic [DATA_W-1:0] grad_in,
  output logic [DATA_W-1:0] bias_out,
  output logic [DATA_W-1:0] grad_sum_out,
  output logic              bias_valid_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  bsize_q, bsize_d;
  logic [DATA_W-1:0] lr_q, lr_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic [DATA_W-1:0] bias_out_q, bias_out_d;
  logic [DATA_W-1:0] sum_out_q, sum_out_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0]        sum16;
  logic signed [PROD_W-1:0] lr_ext;
  logic signed [PROD_W-1:0] sum_ext;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [PROD_W-1:0] prod_shift;
  logic [DATA_W-1:0]        prod16;
  logic signed [DATA_W:0]   diff17;
  logic [DATA_W-1:0]        bias_new;
  logic [CNT_W-1:0]         cnt_inc;
  logic [ACC_W-1:0]         grad_ext;

  // Saturating SGD arithmetic; a value fits 16 bits when all bits above
  // the 16-bit sign bit agree with it.
  always_comb begin
    if ((&acc_q[ACC_W-1:DATA_W-1]) || !(|acc_q[ACC_W-1:DATA_W-1]))
      sum16 = acc_q[DATA_W-1:0];
    else
      sum16 = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;

    lr_ext     = {{(PROD_W-DATA_W){lr_q[DATA_W-1]}}, lr_q};
    sum_ext    = {{(PROD_W-DATA_W){sum16[DATA_W-1]}}, sum16};
    prod_full  = lr_ext * sum_ext;
    prod_shift = prod_full >>> FRAC_W;

    if ((&prod_shift[PROD_W-1:DATA_W-1]) || !(|prod_shift[PROD_W-1:DATA_W-1]))
      prod16 = prod_shift[DATA_W-1:0];
    else
      prod16 = prod_shift[PROD_W-1] ? SAT_MIN : SAT_MAX;

    diff17 = $signed({bias_q[DATA_W-1], bias_q}) - $signed({prod16[DATA_W-1], prod16});
    if (diff17[DATA_W] == diff17[DATA_W-1])
      bias_new = diff17[DATA_W-1:0];
    else
      bias_new = diff17[DATA_W] ? SAT_MIN : SAT_MAX;
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bsize_d    = bsize_q;
    lr_d       = lr_q;
    bias_d     = bias_q;
    bias_out_d = '0;
    sum_out_d  = '0;
    valid_d    = 1'b0;
    cnt_inc    = cnt_q + CNT_W'(1);
    grad_ext   = {{(ACC_W-DATA_W){grad_in[DATA_W-1]}}, grad_in};

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_in) begin
          bsize_d = batch_size_in;
          lr_d    = lr_in;
          bias_d  = bias_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (batch_size_in == '0) ? ST_UPDATE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (grad_valid_in) begin
          acc_d = acc_q + grad_ext;
          cnt_d = cnt_inc;
          if (cnt_inc == bsize_q)
            state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        bias_out_d = bias_new;
        sum_out_d  = sum16;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      bsize_q    <= '0;
      lr_q       <= '0;
      bias_q     <= '0;
      bias_out_q <= '0;
      sum_out_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      bsize_q    <= bsize_d;
      lr_q       <= lr_d;
      bias_q     <= bias_d;
      bias_out_q <= bias_out_d;
      sum_out_q  <= sum_out_d;
      valid_q    <= valid_d;
    end
  end

  assign bias_out       = bias_out_q;
  assign grad_sum_out   = sum_out_q;
  assign bias_valid_out = valid_q;
  assign busy_out       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bias_grad_update.sv
// Scoreboard bench for bias_grad_update: the driver pushes hand-computed
// results with the cycle they must appear in; the monitor pops on each pulse.
module tb_bias_grad_update;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid_in = 1'b0;
  logic [7:0]  batch_size_in = '0;
  logic [15:0] lr_in = '0;
  logic [15:0] bias_in = '0;
  logic        grad_valid_in = 1'b0;
  logic [15:0] grad_in = '0;
  logic [15:0] bias_out;
  logic [15:0] grad_sum_out;
  logic        bias_valid_out;
  logic        busy_out;

  bias_grad_update #(.DATA_W(16), .FRAC_W(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_in(cfg_valid_in), .batch_size_in(batch_size_in),
    .lr_in(lr_in), .bias_in(bias_in),
    .grad_valid_in(grad_valid_in), .grad_in(grad_in),
    .bias_out(bias_out), .grad_sum_out(grad_sum_out),
    .bias_valid_out(bias_valid_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bias;
    logic [15:0] sum;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, sampled at the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Call just before driving the last grad (or a zero-batch cfg):
  // that input is sampled at edge cyc+1, the pulse is seen in cycle cyc+2.
  task automatic expect_result(input logic [15:0] b, input logic [15:0] s);
    exp_t e;
    e.bias   = b;
    e.sum    = s;
    e.at_cyc = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input logic [7:0] bs, input logic [15:0] lr, input logic [15:0] b);
    cfg_valid_in  = 1'b1;
    batch_size_in = bs;
    lr_in         = lr;
    bias_in       = b;
    tick();
    cfg_valid_in  = 1'b0;
  endtask

  task automatic grad(input logic [15:0] g);
    grad_valid_in = 1'b1;
    grad_in       = g;
    tick();
    grad_valid_in = 1'b0;
  endtask

  // Monitor: compare every pulse against the scoreboard head; outside a
  // pulse the result outputs must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bias_valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: bias_out 0x%0h sum 0x%0h at cycle %0d, none expected",
                   bias_out, grad_sum_out, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bias_out", {16'h0, bias_out}, {16'h0, e.bias});
          chk("grad_sum_out", {16'h0, grad_sum_out}, {16'h0, e.sum});
          chk("pulse_cycle", cyc, e.at_cyc);
          chk("busy_in_pulse", {31'h0, busy_out}, 32'h0);
        end
      end else begin
        chk("idle_outputs_zero", {bias_out, grad_sum_out}, 32'h0);
      end
    end
  end

  initial begin
    idle(3);
    chk("reset_outputs", {bias_out, grad_sum_out}, 32'h0);
    chk("reset_valid_busy", {30'h0, bias_valid_out, busy_out}, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Basic: 4 x 1.0, lr 0.5, bias 2.0 -> sum 4.0, bias 0
    cfg(8'd4, 16'h0080, 16'h0200);
    chk("busy_after_cfg", {31'h0, busy_out}, 32'h1);
    grad(16'h0100); grad(16'h0100); grad(16'h0100);
    expect_result(16'h0000, 16'h0400);
    grad(16'h0100);
    idle(3);

    // Gaps: sum 0x0280, prod 0x0140, bias 0x00C0; busy held through gaps
    cfg(8'd4, 16'h0080, 16'h0200);
    grad(16'h0100); idle(2);
    chk("busy_gap1", {31'h0, busy_out}, 32'h1);
    grad(16'hFF00); idle(3);
    chk("busy_gap2", {31'h0, busy_out}, 32'h1);
    grad(16'h0200); idle(1);
    chk("busy_gap3", {31'h0, busy_out}, 32'h1);
    expect_result(16'h00C0, 16'h0280);
    grad(16'h0080);
    idle(3);

    // Saturation of sum and of bias subtraction
    cfg(8'd4, 16'h0100, 16'h9000);
    grad(16'h7000); grad(16'h7000); grad(16'h7000);
    expect_result(16'h8000, 16'h7FFF);
    grad(16'h7000);
    idle(3);

    // Floor on negative product: -1/256 * 0.5 floors to -1 lsb
    cfg(8'd1, 16'h0080, 16'h0000);
    expect_result(16'h0001, 16'hFFFF);
    grad(16'hFFFF);
    idle(3);

    // Product saturation: lr -128 * sum 32767 -> prod clamps to -32768
    cfg(8'd1, 16'h8000, 16'h0000);
    expect_result(16'h7FFF, 16'h7FFF);
    grad(16'h7FFF);
    idle(3);

    // Grads in IDLE ignored, including one alongside a zero-batch cfg
    grad(16'h7FFF); idle(1); grad(16'h1000);
    grad_valid_in = 1'b1;
    grad_in       = 16'h7FFF;
    expect_result(16'h1234, 16'h0000);
    cfg(8'd0, 16'h0100, 16'h1234);
    grad_valid_in = 1'b0;
    idle(3);

    // cfg during ACCUM must not disturb latched lr/bias/batch
    cfg(8'd2, 16'h0100, 16'h0100);
    grad(16'h0100);
    cfg(8'd1, 16'h7FFF, 16'h5555);
    expect_result(16'hFF00, 16'h0200);
    grad(16'h0100);
    idle(3);

    // Reset mid-batch: no pulse, outputs zero, later grads ignored
    cfg(8'd4, 16'h0100, 16'h0100);
    grad(16'h0100); grad(16'h0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'h0, busy_out}, 32'h0);
    chk("rst_mid_outputs", {bias_out, grad_sum_out}, 32'h0);
    grad(16'h0100); grad(16'h0100);
    chk("rst_mid_stays_idle", {31'h0, busy_out}, 32'h0);
    idle(3);

    // Back-to-back: second cfg in the pulse cycle of the first
    cfg(8'd1, 16'h0100, 16'h0100);
    expect_result(16'hFE00, 16'h0300);
    grad(16'h0300);
    idle(1);
    chk("b2b_pulse_now", {31'h0, bias_valid_out}, 32'h1);
    cfg(8'd1, 16'h0200, 16'h0400);
    chk("b2b_accepted", {31'h0, busy_out}, 32'h1);
    expect_result(16'h0300, 16'h0080);
    grad(16'h0080);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bias_grad_update.md
Name: bias_grad_update

Overview:
Backward-pass counterpart of the forward bias adder. It accumulates per-column bias gradients (deltas) streamed out of the systolic array over one batch. It then applies the SGD step bias_new = bias - lr * sum(grad) and emits the updated bias for write-back to the bias store. One instance per array column. All data is signed Q8.8 fixed point.

Parameters:
DATA_W, 16, data width of grad/bias/lr (signed fixed point)
FRAC_W, 8, fractional bits of the fixed-point format
ACC_W, 24, internal accumulator width (signed)
CNT_W, 8, width of batch size and sample counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
cfg_valid_in  input  1  starts an update; latches batch_size_in, lr_in, bias_in (accepted only in IDLE)
batch_size_in  input  CNT_W  number of gradient samples in the batch (unsigned)
lr_in  input  DATA_W  learning rate, signed Q8.8
bias_in  input  DATA_W  current bias, signed Q8.8
grad_valid_in  input  1  grad_in valid this cycle
grad_in  input  DATA_W  gradient sample, signed Q8.8
bias_out  output  DATA_W  updated bias, valid with bias_valid_out, else 0
grad_sum_out  output  DATA_W  saturated gradient sum, valid with bias_valid_out, else 0
bias_valid_out  output  1  one-cycle pulse, result valid
busy_out  output  1  high whenever state != IDLE

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-operation):
  - state=IDLE; accumulator, counter and latched config cleared.
  - bias_out=0, grad_sum_out=0, bias_valid_out=0, busy_out=0.
  - A batch in progress is abandoned; no output pulse.
- States: IDLE, ACCUM, UPDATE.
- IDLE:
  - grad_valid_in ignored.
  - On cfg_valid_in: latch batch_size, lr, bias; clear accumulator and counter.
  - batch_size_in != 0 -> ACCUM. batch_size_in == 0 -> UPDATE directly with sum=0.
- ACCUM:
  - Each cycle with grad_valid_in=1: acc <= acc + sign-extended grad_in; count <= count + 1.
  - acc wraps at ACC_W; batches up to 255 of full-scale values cannot overflow 24 bits.
  - Cycles with grad_valid_in=0 leave the state unchanged (gaps allowed, no timeout).
  - The sample that makes count == batch_size is accumulated, then state -> UPDATE.
  - cfg_valid_in is ignored in ACCUM and UPDATE.
- UPDATE (exactly one cycle):
  - sum16 = acc saturated to [-32768, 32767].
  - prod = lr * sum16, a full 32-bit signed product, arithmetically shifted right by FRAC_W (floor, no rounding), then saturated to 16 bits.
  - bias_new = bias - prod, computed at 17 bits, then saturated to 16 bits.
  - Registered at the next edge: bias_out=bias_new, grad_sum_out=sum16, bias_valid_out=1; state -> IDLE.
- Latency: if the last grad is sampled at edge k, bias_valid_out is high during the cycle following edge k+1.
  - batch_size=0: cfg sampled at edge k, so the pulse follows edge k+1.
- bias_valid_out is high exactly one cycle. The next cycle it returns to 0, and bias_out and grad_sum_out return to 0.
- busy_out is 0 in the cycle where bias_valid_out=1, because the state is already IDLE.
  - A cfg_valid_in in that cycle is accepted (back-to-back updates allowed).
- grad_valid_in asserted together with cfg_valid_in in IDLE: that grad is ignored. The first accumulated sample is the next valid.

Test Plan:
- Basic: cfg batch=4, lr=0x0080 (0.5), bias=0x0200 (2.0); four grads 0x0100 back-to-back -> grad_sum_out=0x0400, bias_out=0x0000, one-cycle pulse 2 edges after the last grad.
- Gaps: same config, grads 0x0100, 0xFF00, 0x0200, 0x0080 with idle cycles between -> sum=0x0280, prod=0x0140, bias_out=0x00C0; busy_out=1 throughout until the pulse.
- Saturation: batch=4, lr=0x0100, bias=0x9000, grads 4x 0x7000 -> grad_sum_out=0x7FFF, bias_out=0x8000.
- Floor on negative: batch=1, lr=0x0080, bias=0x0000, grad=0xFFFF -> sum=0xFFFF, prod=-1, bias_out=0x0001.
- Zero batch / ignored inputs: grad_valid_in pulses in IDLE then cfg batch=0, bias=0x1234 -> pulse next cycle with bias_out=0x1234, grad_sum_out=0; cfg_valid_in during ACCUM does not change the latched lr or bias.
- Reset mid-batch and back-to-back: rst after 2 of 4 grads -> all outputs 0, no pulse; a new cfg is accepted in the same cycle as bias_valid_out -> the second result is correct and independent of the first.
